// File: rtl/mod_exp_seq.sv
// Sequential modular exponentiator: left-to-right square-and-multiply built on
// a bit-serial interleaved modular multiplier that takes WIDTH cycles per product.
module mod_exp_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] exponent,
  input  logic [31:0]      length,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] base_r, mod_r, exp_r, acc;
  logic [WIDTH+1:0] p, p_sum, p_red1, p_red2, mcand_ext, mod_ext;
  logic [IW-1:0]    bit_cnt, idx, len_clamped;
  logic             last_bit, exp_bit, zero_exp;

  // One interleaved step: P = 2P (+ b when the multiplier bit is set), then two conditional subtracts.
  always_comb begin
    mcand_ext   = '0;
    mod_ext     = {2'b00, mod_r};
    mcand_ext   = (state == MUL) ? {2'b00, base_r} : {2'b00, acc};
    p_sum       = (p << 1) + (acc[bit_cnt] ? mcand_ext : '0);
    p_red1      = (p_sum >= mod_ext) ? (p_sum - mod_ext) : p_sum;
    p_red2      = (p_red1 >= mod_ext) ? (p_red1 - mod_ext) : p_red1;
    last_bit    = (bit_cnt == '0);
    exp_bit     = exp_r[idx];
    zero_exp    = (length == 32'hFFFF_FFFF);
    len_clamped = (length >= 32'(WIDTH)) ? IW'(WIDTH - 1) : length[IW-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: if (start) state_next = zero_exp ? DONE : SQR;
      SQR: begin
        if (last_bit) begin
          if (exp_bit)          state_next = MUL;
          else if (idx == '0)   state_next = DONE;
          else                  state_next = SQR;
        end
      end
      MUL:  if (last_bit) state_next = (idx == '0) ? DONE : SQR;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // result is loaded on entry to DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_r  <= '0;
      mod_r   <= '0;
      exp_r   <= '0;
      acc     <= '0;
      p       <= '0;
      bit_cnt <= '0;
      idx     <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_r  <= base;
            mod_r   <= modulus;
            exp_r   <= exponent;
            idx     <= len_clamped;
            acc     <= WIDTH'(1);
            p       <= '0;
            bit_cnt <= IW'(WIDTH - 1);
            if (zero_exp) result <= WIDTH'(1);
          end
        end
        SQR, MUL: begin
          if (last_bit) begin
            acc     <= p_red2[WIDTH-1:0];
            p       <= '0;
            bit_cnt <= IW'(WIDTH - 1);
            if ((state == MUL || !exp_bit) && idx != '0) idx <= idx - IW'(1);
            if (state_next == DONE) result <= p_red2[WIDTH-1:0];
          end else begin
            p       <= p_red2;
            bit_cnt <= bit_cnt - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mod_exp_seq.md
MOD_EXP_SEQ -- requirements
Module: mod_exp_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the operand width of base, modulus, exponent and result.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin an exponentiation, sampled only when idle.
REQ-005 SHALL have port base, input, WIDTH bits: base operand, precondition base < modulus.
REQ-006 SHALL have port modulus, input, WIDTH bits: modulus, precondition modulus >= 2.
REQ-007 SHALL have port exponent, input, WIDTH bits: exponent operand.
REQ-008 SHALL have port length, input, 32 bits: index of the exponent's highest set bit from the upstream bit-length stage; 0xFFFFFFFF (-1) means exponent is zero.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port result, output, WIDTH bits: base^exponent mod modulus.

Function
REQ-012 SHALL compute the result by left-to-right square-and-multiply: acc = 1; for i = L down to 0: acc = acc*acc mod n; if exponent[i], acc = acc*base mod n.
REQ-013 SHALL perform each modular multiply bit-serially, interleaved, MSB first, one multiplier bit per clock: P = 2P; if a[j], P += b; then subtract n while P >= n (at most twice); P held in WIDTH+2 bits.
REQ-014 SHALL take exactly WIDTH cycles per modular multiply, with no idle cycles between multiplies.
REQ-015 SHALL use states IDLE, SQR, MUL and DONE.
REQ-016 IDLE: when start=1, SHALL latch base, modulus, exponent and L, set acc=1 and go to SQR; if L = -1, SHALL go directly to DONE instead.
REQ-017 SQR: after WIDTH cycles, SHALL go to MUL if exponent[i]=1; otherwise, if i=0, go to DONE, else decrement i and go to SQR.
REQ-018 MUL: after WIDTH cycles, if i=0, SHALL go to DONE, else decrement i and go to SQR.
REQ-019 DONE: SHALL last one cycle, drive done=1, load result with acc and return to IDLE.
REQ-020 Latency: with K = (L+1) + popcount(exponent[L:0]), done SHALL be high in the cycle following clock edge K*WIDTH+1, counted from the edge that sampled start; for L=-1 (K=0), done SHALL be high after edge 1.
REQ-021 busy SHALL be 1 in every cycle from the edge after start is sampled through the DONE cycle inclusive, and 0 in IDLE.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the in-flight operation.
REQ-023 result SHALL hold its value from DONE until the next DONE; it SHALL NOT change during an operation.
REQ-024 length values from WIDTH to 0xFFFFFFFE SHALL be clamped to WIDTH-1.
REQ-025 Input changes after the start sample SHALL NOT affect the operation.
REQ-026 With a violated precondition (modulus < 2 or base >= modulus), result is unspecified, but done SHALL still occur at the REQ-020 latency.
REQ-027 start asserted in the DONE cycle SHALL be ignored; it is accepted from the following IDLE cycle.

Reset
REQ-028 rstn low SHALL immediately force state IDLE, busy=0, done=0, result=0, and clear all internal counters and accumulators.
REQ-029 Reset mid-operation SHALL abandon the operation with no done pulse; the next start after rstn rises SHALL operate normally.

Verification
REQ-030 base=4, exponent=13, length=3, modulus=497 -> K=7, done after edge 449, result=445.
REQ-031 exponent=0, length=0xFFFFFFFF, any valid base/modulus -> done after edge 1, result=1, busy high for one cycle.
REQ-032 base=5, exponent=1, length=0, modulus=7 -> K=2, done after edge 129, result=5.
REQ-033 modulus=0xFFFFFFFFFFFFFFC5 (prime), base=2, exponent=modulus-1, length=63 -> result=1 (Fermat), done at the REQ-020 latency.
REQ-034 Start an operation, pulse start again at cycle 10, then assert rstn low at cycle 100 -> second start ignored; on reset, busy=0, done=0, result=0 and no done pulse; a new start after reset gives the correct result.
REQ-035 Back-to-back operations: start in the first IDLE cycle after done -> accepted; previous result held until the new DONE.
